// File: rtl/jtag_pkg.sv
// jtag_pkg: shared TAP state encoding, instruction codes and capture pattern.
package jtag_pkg;
    typedef enum logic [3:0] {
        TEST_LOGIC_RESET, RUN_TEST_IDLE,
        SELECT_DR_SCAN, CAPTURE_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPDATE_DR,
        SELECT_IR_SCAN, CAPTURE_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPDATE_IR
    } tap_ctrl_fsm_t;

    localparam int IR_IDCODE = 1;
    localparam logic [1:0] IR_CAPTURE_PAT = 2'b01;

    function automatic int ir_user(input int k, input int w);
        return (2 + k) & ((1 << w) - 1);
    endfunction
endpackage

// File: rtl/jtag_tap_multi_dr_fsm.sv
// tap_ctrl_fsm: the 16-state IEEE 1149.1 TAP controller, advancing on rising tck.
module tap_ctrl_fsm
    import jtag_pkg::*;
(
    input  logic          tck,
    input  logic          trstn,
    input  logic          tms,
    output tap_ctrl_fsm_t state_q,
    output tap_ctrl_fsm_t state_d
);
    always_comb begin
        state_d = state_q;
        case (state_q)
            TEST_LOGIC_RESET: state_d = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
            RUN_TEST_IDLE:    state_d = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            SELECT_DR_SCAN:   state_d = tms ? SELECT_IR_SCAN   : CAPTURE_DR;
            CAPTURE_DR:       state_d = tms ? EXIT1_DR         : SHIFT_DR;
            SHIFT_DR:         state_d = tms ? EXIT1_DR         : SHIFT_DR;
            EXIT1_DR:         state_d = tms ? UPDATE_DR        : PAUSE_DR;
            PAUSE_DR:         state_d = tms ? EXIT2_DR         : PAUSE_DR;
            EXIT2_DR:         state_d = tms ? UPDATE_DR        : SHIFT_DR;
            UPDATE_DR:        state_d = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            SELECT_IR_SCAN:   state_d = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:       state_d = tms ? EXIT1_IR         : SHIFT_IR;
            SHIFT_IR:         state_d = tms ? EXIT1_IR         : SHIFT_IR;
            EXIT1_IR:         state_d = tms ? UPDATE_IR        : PAUSE_IR;
            PAUSE_IR:         state_d = tms ? EXIT2_IR         : PAUSE_IR;
            EXIT2_IR:         state_d = tms ? UPDATE_IR        : SHIFT_IR;
            UPDATE_IR:        state_d = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
        endcase
    end

    always_ff @(posedge tck or negedge trstn)
        if (!trstn) state_q <= TEST_LOGIC_RESET;
        else        state_q <= state_d;
endmodule

// File: rtl/jtag_tap_multi_dr.sv
// jtag_tap_multi_dr: 1149.1 TAP with IDCODE, BYPASS and NUM_USER_DR user data registers.
// tdo/tdo_en are retimed to falling tck so the host samples them on the next rising edge.
module jtag_tap_multi_dr
    import jtag_pkg::*;
#(
    parameter int          IR_WIDTH    = 4,
    parameter int          NUM_USER_DR = 2,
    parameter int          DR_WIDTH    = 32,
    parameter logic [31:0] IDCODE_VAL  = 32'h10F
) (
    input  logic                            tck,
    input  logic                            trstn,
    input  logic                            tms,
    input  logic                            tdi,
    output logic                            tdo,
    output logic                            tdo_en,
    output tap_ctrl_fsm_t                   tap_state,
    output logic [IR_WIDTH-1:0]             ir_q,
    input  logic [NUM_USER_DR*DR_WIDTH-1:0] dr_capture_val,
    output logic [NUM_USER_DR*DR_WIDTH-1:0] dr_update_val,
    output logic [NUM_USER_DR-1:0]          dr_update_pulse
);
    tap_ctrl_fsm_t state_next;
    logic [IR_WIDTH-1:0] ir_sr_q, ir_sr_d, ir_d;
    logic [31:0] id_sr_q, id_sr_d;
    logic byp_q, byp_d, tdo_d, tdo_en_d, id_sel, dr_lsb;
    logic cap_dr, shift_dr;
    logic [NUM_USER_DR-1:0] user_sel, user_lsb;

    tap_ctrl_fsm u_fsm (
        .tck     (tck),
        .trstn   (trstn),
        .tms     (tms),
        .state_q (tap_state),
        .state_d (state_next)
    );

    assign cap_dr   = tap_state == CAPTURE_DR;
    assign shift_dr = tap_state == SHIFT_DR;
    assign id_sel   = ir_q == IR_WIDTH'(IR_IDCODE);

    // Registers update on the edge entering Update-*, so values are valid while the strobe is high.
    for (genvar k = 0; k < NUM_USER_DR; k++) begin : g_user
        logic [DR_WIDTH-1:0] sr_q, sr_d, upd_q, upd_d;
        assign user_sel[k]        = ir_q == IR_WIDTH'(ir_user(k, IR_WIDTH));
        assign user_lsb[k]        = user_sel[k] & sr_q[0];
        assign dr_update_pulse[k] = user_sel[k] && tap_state == UPDATE_DR;
        assign dr_update_val[k*DR_WIDTH +: DR_WIDTH] = upd_q;
        always_comb begin
            sr_d  = !user_sel[k] ? sr_q :
                    cap_dr       ? dr_capture_val[k*DR_WIDTH +: DR_WIDTH] :
                    shift_dr     ? {tdi, sr_q[DR_WIDTH-1:1]} : sr_q;
            upd_d = (user_sel[k] && state_next == UPDATE_DR) ? sr_q : upd_q;
        end
        always_ff @(posedge tck or negedge trstn)
            if (!trstn) begin
                sr_q  <= '0;
                upd_q <= '0;
            end else begin
                sr_q  <= sr_d;
                upd_q <= upd_d;
            end
    end

    always_comb begin
        ir_sr_d  = tap_state == CAPTURE_IR ? IR_WIDTH'(IR_CAPTURE_PAT) :
                   tap_state == SHIFT_IR   ? {tdi, ir_sr_q[IR_WIDTH-1:1]} : ir_sr_q;
        ir_d     = state_next == TEST_LOGIC_RESET ? IR_WIDTH'(IR_IDCODE) :
                   state_next == UPDATE_IR        ? ir_sr_q : ir_q;
        id_sr_d  = !id_sel  ? id_sr_q :
                   cap_dr   ? IDCODE_VAL :
                   shift_dr ? {tdi, id_sr_q[31:1]} : id_sr_q;
        byp_d    = (id_sel || |user_sel) ? byp_q : cap_dr ? 1'b0 : shift_dr ? tdi : byp_q;
        dr_lsb   = id_sel ? id_sr_q[0] : |user_sel ? |user_lsb : byp_q;
        tdo_en_d = tap_state == SHIFT_IR || shift_dr;
        tdo_d    = tap_state == SHIFT_IR ? ir_sr_q[0] : shift_dr ? dr_lsb : 1'b0;
    end

    always_ff @(posedge tck or negedge trstn)
        if (!trstn) begin
            ir_sr_q <= '0;
            ir_q    <= IR_WIDTH'(IR_IDCODE);
            id_sr_q <= '0;
            byp_q   <= 1'b0;
        end else begin
            ir_sr_q <= ir_sr_d;
            ir_q    <= ir_d;
            id_sr_q <= id_sr_d;
            byp_q   <= byp_d;
        end

    always_ff @(negedge tck or negedge trstn)
        if (!trstn) begin
            tdo    <= 1'b0;
            tdo_en <= 1'b0;
        end else begin
            tdo    <= tdo_d;
            tdo_en <= tdo_en_d;
        end
endmodule

// File: tb/tb_jtag_tap_multi_dr.sv
// tb_jtag_tap_multi_dr: directed scenarios for the multi-DR TAP with hand-computed expectations.
module tb_jtag_tap_multi_dr;
    import jtag_pkg::*;

    logic tck = 1'b0, trstn = 1'b1, tms = 1'b1, tdi = 1'b0;
    logic tdo, tdo_en;
    tap_ctrl_fsm_t tap_state;
    logic [3:0] ir_q;
    logic [63:0] dr_capture_val = 64'h0;
    logic [63:0] dr_update_val;
    logic [1:0] dr_update_pulse;
    int compared = 0, mismatched = 0;

    jtag_tap_multi_dr dut (
        .tck             (tck),
        .trstn           (trstn),
        .tms             (tms),
        .tdi             (tdi),
        .tdo             (tdo),
        .tdo_en          (tdo_en),
        .tap_state       (tap_state),
        .ir_q            (ir_q),
        .dr_capture_val  (dr_capture_val),
        .dr_update_val   (dr_update_val),
        .dr_update_pulse (dr_update_pulse)
    );

    always #5 tck = ~tck;

    task automatic step(input logic m, input logic d);
        tms = m;
        tdi = d;
        @(posedge tck);
        #1;
    endtask

    task automatic shift(input int n, input logic [31:0] din, input bit ex, output logic [31:0] dout);
        dout = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge tck);
            #1;
            dout[i] = tdo;
            tms = ex && (i == n - 1);
            tdi = din[i];
            @(posedge tck);
            #1;
        end
    endtask

    task automatic goto_shift_dr;
        step(1, 0); step(0, 0); step(0, 0);
    endtask

    task automatic goto_shift_ir;
        step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    endtask

    task automatic load_ir(input logic [3:0] v);
        logic [31:0] dummy;
        goto_shift_ir;
        shift(4, {28'h0, v}, 1, dummy);
        step(1, 0); step(0, 0);
    endtask

    task automatic test_reset;
        #2 trstn = 1'b0;
        #20;
        compared += 6;
        if (tap_state !== TEST_LOGIC_RESET) begin mismatched++; $display("FAIL reset_state got %0d exp %0d", tap_state, TEST_LOGIC_RESET); end
        if (ir_q !== 4'h1) begin mismatched++; $display("FAIL reset_ir got %h exp 1", ir_q); end
        if (tdo !== 1'b0) begin mismatched++; $display("FAIL reset_tdo got %b exp 0", tdo); end
        if (tdo_en !== 1'b0) begin mismatched++; $display("FAIL reset_tdo_en got %b exp 0", tdo_en); end
        if (dr_update_val !== 64'h0) begin mismatched++; $display("FAIL reset_upd_val got %h exp 0", dr_update_val); end
        if (dr_update_pulse !== 2'b00) begin mismatched++; $display("FAIL reset_pulse got %b exp 00", dr_update_pulse); end
        trstn = 1'b1;
        step(0, 0);
        compared += 2;
        if (tap_state !== RUN_TEST_IDLE) begin mismatched++; $display("FAIL rti_state got %0d exp %0d", tap_state, RUN_TEST_IDLE); end
        if (ir_q !== 4'h1) begin mismatched++; $display("FAIL rti_ir got %h exp 1", ir_q); end
    endtask

    task automatic test_idcode;
        logic [31:0] out;
        goto_shift_dr;
        shift(32, 32'h0, 1, out);
        step(1, 0); step(0, 0);
        compared += 2;
        if (out !== 32'h0000010F) begin mismatched++; $display("FAIL idcode_shift got %h exp 0000010f", out); end
        if (ir_q !== 4'h1) begin mismatched++; $display("FAIL idcode_ir got %h exp 1", ir_q); end
    endtask

    task automatic test_pause_resume;
        logic [31:0] lo, hi;
        goto_shift_dr;
        shift(16, 32'h0, 1, lo);
        step(0, 0); step(0, 0);
        compared++;
        if (tdo_en !== 1'b0) begin mismatched++; $display("FAIL pause_tdo_en got %b exp 0", tdo_en); end
        step(1, 0); step(0, 0);
        shift(16, 32'h0, 1, hi);
        step(1, 0); step(0, 0);
        compared++;
        if ({hi[15:0], lo[15:0]} !== 32'h0000010F) begin mismatched++; $display("FAIL pause_resume got %h exp 0000010f", {hi[15:0], lo[15:0]}); end
    endtask

    task automatic test_tlr;
        load_ir(4'hF);
        goto_shift_dr;
        repeat (5) step(1, 0);
        compared += 3;
        if (tap_state !== TEST_LOGIC_RESET) begin mismatched++; $display("FAIL tlr_state got %0d exp %0d", tap_state, TEST_LOGIC_RESET); end
        if (ir_q !== 4'h1) begin mismatched++; $display("FAIL tlr_ir got %h exp 1", ir_q); end
        if (tdo_en !== 1'b0) begin mismatched++; $display("FAIL tlr_tdo_en got %b exp 0", tdo_en); end
        step(0, 0);
    endtask

    task automatic test_bypass;
        logic [31:0] out;
        logic [3:0] codes [2] = '{4'hF, 4'h9};
        for (int c = 0; c < 2; c++) begin
            load_ir(codes[c]);
            goto_shift_dr;
            shift(5, 32'h0000000B, 1, out);
            step(1, 0); step(0, 0);
            compared++;
            if (out[4:0] !== 5'b10110) begin mismatched++; $display("FAIL bypass_ir%h got %b exp 10110", codes[c], out[4:0]); end
        end
    endtask

    task automatic test_ir_capture;
        logic [31:0] out;
        goto_shift_ir;
        shift(4, 32'h0, 1, out);
        step(1, 0); step(0, 0);
        compared += 2;
        if (out[3:0] !== 4'b0001) begin mismatched++; $display("FAIL ir_capture got %b exp 0001", out[3:0]); end
        if (ir_q !== 4'h0) begin mismatched++; $display("FAIL ir_update got %h exp 0", ir_q); end
    endtask

    task automatic test_user0;
        logic [31:0] out;
        dr_capture_val = {32'h0, 32'h12345678};
        load_ir(4'h2);
        goto_shift_dr;
        shift(32, 32'hDEADBEEF, 1, out);
        step(1, 0);
        compared += 4;
        if (out !== 32'h12345678) begin mismatched++; $display("FAIL user0_capture got %h exp 12345678", out); end
        if (dr_update_val[31:0] !== 32'hDEADBEEF) begin mismatched++; $display("FAIL user0_upd got %h exp deadbeef", dr_update_val[31:0]); end
        if (dr_update_val[63:32] !== 32'h0) begin mismatched++; $display("FAIL user0_other got %h exp 0", dr_update_val[63:32]); end
        if (dr_update_pulse !== 2'b01) begin mismatched++; $display("FAIL user0_pulse got %b exp 01", dr_update_pulse); end
        step(0, 0);
        compared += 2;
        if (dr_update_pulse !== 2'b00) begin mismatched++; $display("FAIL user0_pulse_end got %b exp 00", dr_update_pulse); end
        if (dr_update_val[31:0] !== 32'hDEADBEEF) begin mismatched++; $display("FAIL user0_hold got %h exp deadbeef", dr_update_val[31:0]); end
    endtask

    task automatic test_readback;
        dr_capture_val = {32'h0, 32'h0BADCAFE};
        step(1, 0); step(0, 0); step(1, 0); step(1, 0);
        compared += 2;
        if (dr_update_val[31:0] !== 32'h0BADCAFE) begin mismatched++; $display("FAIL readback_upd got %h exp 0badcafe", dr_update_val[31:0]); end
        if (dr_update_pulse !== 2'b01) begin mismatched++; $display("FAIL readback_pulse got %b exp 01", dr_update_pulse); end
        step(0, 0);
    endtask

    task automatic test_user1;
        logic [31:0] out;
        dr_capture_val = {32'hCAFEF00D, 32'h0BADCAFE};
        load_ir(4'h3);
        goto_shift_dr;
        shift(32, 32'hA5A5A5A5, 1, out);
        step(1, 0);
        compared += 3;
        if (out !== 32'hCAFEF00D) begin mismatched++; $display("FAIL user1_capture got %h exp cafef00d", out); end
        if (dr_update_val !== 64'hA5A5A5A5_0BADCAFE) begin mismatched++; $display("FAIL user1_upd got %h exp a5a5a5a50badcafe", dr_update_val); end
        if (dr_update_pulse !== 2'b10) begin mismatched++; $display("FAIL user1_pulse got %b exp 10", dr_update_pulse); end
        step(0, 0);
    endtask

    task automatic test_abort;
        goto_shift_dr;
        for (int i = 0; i < 16; i++) step(0, i[0]);
        compared++;
        if (tdo_en !== 1'b1) begin mismatched++; $display("FAIL abort_pre_tdo_en got %b exp 1", tdo_en); end
        trstn = 1'b0;
        #1;
        compared += 6;
        if (dr_update_pulse !== 2'b00) begin mismatched++; $display("FAIL abort_pulse got %b exp 00", dr_update_pulse); end
        if (dr_update_val !== 64'h0) begin mismatched++; $display("FAIL abort_upd got %h exp 0", dr_update_val); end
        if (tdo_en !== 1'b0) begin mismatched++; $display("FAIL abort_tdo_en got %b exp 0", tdo_en); end
        if (tdo !== 1'b0) begin mismatched++; $display("FAIL abort_tdo got %b exp 0", tdo); end
        if (ir_q !== 4'h1) begin mismatched++; $display("FAIL abort_ir got %h exp 1", ir_q); end
        if (tap_state !== TEST_LOGIC_RESET) begin mismatched++; $display("FAIL abort_state got %0d exp %0d", tap_state, TEST_LOGIC_RESET); end
        #2 trstn = 1'b1;
        step(0, 0);
    endtask

    initial begin
        test_reset;
        test_idcode;
        test_pause_resume;
        test_tlr;
        test_bypass;
        test_ir_capture;
        test_user0;
        test_readback;
        test_user1;
        test_abort;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
